// File: rtl/arb_pkg.sv
// Shared mode constants, default widths and the rotate-and-find-first search
// used by the write-path arbiter.
package arb_pkg;

  localparam logic ARB_MODE_SP   = 1'b0;
  localparam logic ARB_MODE_WRR  = 1'b1;

  localparam int ARB_MAX_PORTS   = 32;
  localparam int DEF_NUM_PORTS   = 16;
  localparam int DEF_DATA_W      = 256;
  localparam int DEF_WEIGHT_W    = 4;

  // Returns {found, index} of the first set request scanning upward from ptr,
  // wrapping modulo n (n <= ARB_MAX_PORTS, ptr < n).
  function automatic logic [5:0] rr_find_first(input logic [ARB_MAX_PORTS-1:0] req,
                                               input logic [4:0]               ptr,
                                               input int unsigned              n);
    logic [5:0]  res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      j = {27'd0, ptr} + k;
      if (j >= n) j = j - n;
      if ((k < n) && !res[5] && req[j[4:0]]) res = {1'b1, j[4:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority picker: one-hot grant and index of the first request at or
// above ptr, with wrap-around.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    idx,
  output logic                 found
);

  logic [ARB_MAX_PORTS-1:0] req_ext;
  logic [4:0]               ptr_ext;
  logic [5:0]               res;
  logic                     unused_res;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_PORTS-1:0]  = req;
    ptr_ext                 = '0;
    ptr_ext[PORT_W-1:0]     = ptr;
    res                     = rr_find_first(req_ext, ptr_ext, NUM_PORTS);
    found                   = res[5];
    idx                     = res[PORT_W-1:0];
    grant                   = '0;
    if (found) grant[idx] = 1'b1;
  end

  assign unused_res = ^res;

endmodule

// File: rtl/wrr_sp_arbiter.sv
// Strict-priority / weighted-round-robin arbiter feeding one registered output.
// Optional packet lock (grant held until in_last) enabled by ARB_PKT_LOCK_EN.
module wrr_sp_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WEIGHT_W  = DEF_WEIGHT_W,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sp0_wrr1,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_p,
  input  logic [NUM_PORTS-1:0]          in_valid,
`ifdef ARB_PKT_LOCK_EN
  input  logic [NUM_PORTS-1:0]          in_last,
`endif
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             data_out,
  output logic [PORT_W-1:0]             out_port
);

  logic                 wrr, load_en, reload, accept, dec, pkt_end, lock_active;
  logic                 force_q, wrr_found, sp_found;
  logic [NUM_PORTS-1:0] elig_raw, elig, wrr_grant, sp_grant, grant;
  logic [PORT_W-1:0]    wrr_idx, sp_idx, gidx, ptr_q, ptr_nxt;
  logic [WEIGHT_W-1:0]  weight_eff [NUM_PORTS];
  logic [WEIGHT_W-1:0]  credit_q   [NUM_PORTS];
  logic [WEIGHT_W-1:0]  credit_eff [NUM_PORTS];
  logic [WEIGHT_W-1:0]  credit_nxt [NUM_PORTS];
  logic [DATA_W-1:0]    data_arr   [NUM_PORTS];

`ifdef ARB_PKT_LOCK_EN
  logic                 lock_q;
  logic [PORT_W-1:0]    lock_idx;
  assign lock_active = lock_q;
`else
  assign lock_active = 1'b0;
`endif

  assign wrr = (sp0_wrr1 == ARB_MODE_WRR);

  // Reload happens in the same cycle it is needed, so the grant sees fresh credits.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      weight_eff[i] = weight_p[i*WEIGHT_W +: WEIGHT_W];
      if (weight_eff[i] == '0) weight_eff[i] = WEIGHT_W'(1);
      data_arr[i]   = data_in_p[i*DATA_W +: DATA_W];
      elig_raw[i]   = in_valid[i] && (credit_q[i] != '0);
    end
    reload = wrr && (in_valid != '0) && (force_q || (elig_raw == '0)) && !lock_active;
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_eff[i] = reload ? weight_eff[i] : credit_q[i];
      elig[i]       = in_valid[i] && (credit_eff[i] != '0);
    end
  end

  rr_prio_pick #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_wrr_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .grant (wrr_grant),
    .idx   (wrr_idx),
    .found (wrr_found)
  );

  rr_prio_pick #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_sp_pick (
    .req   (in_valid),
    .ptr   ('0),
    .grant (sp_grant),
    .idx   (sp_idx),
    .found (sp_found)
  );

  always_comb begin
    grant   = wrr ? wrr_grant : sp_grant;
    gidx    = wrr ? wrr_idx   : sp_idx;
    pkt_end = 1'b1;
`ifdef ARB_PKT_LOCK_EN
    if (lock_q) begin
      grant           = '0;
      grant[lock_idx] = in_valid[lock_idx];
      gidx            = lock_idx;
    end
    pkt_end = in_last[gidx];
`endif
    load_en  = !out_valid || out_ready;
    accept   = load_en && (grant != '0);
    in_ready = (load_en && !rst) ? grant : '0;
    dec      = accept && wrr && pkt_end;
  end

  // Pointer parks on the granted port until its credit runs out.
  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_nxt[i] = credit_eff[i];
      if (dec && (gidx == PORT_W'(i)) && (credit_eff[i] != '0))
        credit_nxt[i] = credit_eff[i] - 1'b1;
    end
    if (dec) begin
      if (credit_nxt[gidx] != '0)                   ptr_nxt = gidx;
      else if (gidx == PORT_W'(NUM_PORTS - 1))      ptr_nxt = '0;
      else                                          ptr_nxt = gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_port  <= '0;
      ptr_q     <= '0;
      force_q   <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) credit_q[i] <= '0;
`ifdef ARB_PKT_LOCK_EN
      lock_q    <= 1'b0;
      lock_idx  <= '0;
`endif
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        data_out  <= data_arr[gidx];
        out_port  <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (!wrr)        force_q <= 1'b1;
      else if (reload) force_q <= 1'b0;
      if (wrr) credit_q <= credit_nxt;
      ptr_q <= ptr_nxt;
`ifdef ARB_PKT_LOCK_EN
      if (accept) begin
        lock_q   <= !in_last[gidx];
        lock_idx <= gidx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wrr_sp_arbiter.sv
// Randomised self-checking bench for wrr_sp_arbiter against a behavioural model
// of the SP/WRR arbitration rules, plus directed scenarios.
module tb_wrr_sp_arbiter;

  localparam int NP = 16;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int PW = 4;

  logic              clk;
  logic              rst;
  logic              sp0_wrr1;
  logic [NP*WW-1:0]  weight_p;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [NP*DW-1:0]  data_in_p;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     data_out;
  logic [PW-1:0]     out_port;
`ifdef ARB_PKT_LOCK_EN
  logic [NP-1:0]     in_last;
  assign in_last = '1;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int          m_cred [NP];
  int          m_ptr;
  bit          m_force;
  bit          m_ov;
  logic [DW-1:0] m_data;
  int          m_port;

  wrr_sp_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .WEIGHT_W(WW), .PORT_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sp0_wrr1  (sp0_wrr1),
    .weight_p  (weight_p),
    .in_valid  (in_valid),
`ifdef ARB_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .data_in_p (data_in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model predicts in_ready before the edge and the
  // output register after it.
  task automatic applyStimulus(input bit r, input bit mode, input logic [NP-1:0] v, input bit ordy);
    int   g;
    int   w;
    int   p;
    bit   found;
    bit   le;
    bit   rl;
    bit   any_elig;
    logic [NP-1:0] exp_rdy;
    @(negedge clk);
    rst       = r;
    sp0_wrr1  = mode;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < NP; i++) data_in_p[i*DW +: DW] = $urandom;
    #1;
    found   = 0;
    g       = 0;
    rl      = 0;
    exp_rdy = '0;
    if (!r) begin
      le = !m_ov || ordy;
      if (mode) begin
        any_elig = 0;
        for (int i = 0; i < NP; i++) if (v[i] && m_cred[i] > 0) any_elig = 1;
        if (v != '0 && (m_force || !any_elig)) begin
          rl = 1;
          for (int i = 0; i < NP; i++) begin
            w = int'(weight_p[i*WW +: WW]);
            m_cred[i] = (w == 0) ? 1 : w;
          end
        end
        for (int k = 0; k < NP; k++) begin
          p = (m_ptr + k) % NP;
          if (!found && v[p] && m_cred[p] > 0) begin found = 1; g = p; end
        end
      end else begin
        for (int i = 0; i < NP; i++) if (!found && v[i]) begin found = 1; g = i; end
      end
      if (found && le) exp_rdy[g] = 1'b1;
    end
    checkOutput("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < NP; i++) m_cred[i] = 0;
      m_ptr = 0; m_force = 1; m_ov = 0; m_data = '0; m_port = 0;
    end else begin
      if (exp_rdy != '0) begin
        if (mode) begin
          m_cred[g]--;
          m_ptr = (m_cred[g] == 0) ? (g + 1) % NP : g;
        end
        m_ov = 1; m_data = data_in_p[g*DW +: DW]; m_port = g;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (!mode)   m_force = 1;
      else if (rl) m_force = 0;
    end
    checkOutput("out_valid", out_valid, m_ov);
    if (m_ov || r) begin
      checkOutput("data_out", data_out, m_data);
      checkOutput("out_port", out_port, m_port);
    end
  endtask

  int wrr_seq [7] = '{0, 1, 1, 2, 3, 3, 3};
  bit rmode;

  initial begin
    rst = 1; sp0_wrr1 = 0; weight_p = '0; in_valid = '0; out_ready = 0; data_in_p = '0;
    m_ptr = 0; m_force = 1; m_ov = 0; m_data = '0; m_port = 0;
    for (int i = 0; i < NP; i++) m_cred[i] = 0;

    $display("[TB] reset / idle");
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, '1, 1);
    applyStimulus(0, 0, '1, 1);
    checkOutput("first_port", out_port, 0);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("idle_valid", out_valid, 0);

    $display("[TB] strict priority");
    applyStimulus(1, 0, '0, 1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 16'h0088, 1);
      checkOutput("sp_port", out_port, 3);
    end

    $display("[TB] weighted round robin");
    weight_p = '0;
    weight_p[0*WW +: WW] = 4'd1;
    weight_p[1*WW +: WW] = 4'd2;
    weight_p[2*WW +: WW] = 4'd0;
    weight_p[3*WW +: WW] = 4'd3;
    applyStimulus(1, 1, '0, 1);
    for (int c = 0; c < 14; c++) begin
      applyStimulus(0, 1, 16'h000F, 1);
      checkOutput("wrr_seq", out_port, wrr_seq[c % 7]);
      checkOutput("wrr_nobubble", out_valid, 1);
    end

    $display("[TB] backpressure");
    applyStimulus(1, 0, '0, 1);
    applyStimulus(0, 0, 16'h0004, 1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 16'h0005, 0);
      checkOutput("bp_port", out_port, 2);
      checkOutput("bp_ready", in_ready, 0);
    end
    applyStimulus(0, 0, 16'h0005, 1);
    checkOutput("bp_resume", out_port, 0);
    applyStimulus(0, 0, 16'h0004, 1);
    checkOutput("bp_next", out_port, 2);

    $display("[TB] wrap and reload");
    weight_p = {NP{4'd1}};
    applyStimulus(1, 1, '0, 1);
    applyStimulus(0, 1, 16'h4000, 1);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 1, 16'h8001, 1);
      checkOutput("wrap_port", out_port, (c % 2 == 0) ? 15 : 0);
    end

    $display("[TB] randomised traffic");
    rmode = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) rmode = ~rmode;
      weight_p = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 63) == 0), rmode, NP'($urandom & $urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrr_sp_arbiter.md
Name: wrr_sp_arbiter

Overview:
- Parametrised successor of the write-path arbiter.
- Selects one of NUM_PORTS input channels per beat and forwards its data to a single registered output toward the SRAM write path.
- Arbitration mode is chosen at runtime: strict priority (SP) or weighted round robin (WRR) with per-port weights.
- Every input and the output use a valid/ready handshake, so backpressure is honoured.

Parameters:
- NUM_PORTS, 16, number of input channels (2..32).
- DATA_W, 256, data width per channel.
- WEIGHT_W, 4, width of each per-port WRR weight.
- PORT_W, $clog2(NUM_PORTS), width of the granted-port index.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sp0_wrr1  in  1  mode: 0 = SP, 1 = WRR.
- weight_p  in  NUM_PORTS*WEIGHT_W  packed weights; port i at [i*WEIGHT_W +: WEIGHT_W].
- in_valid  in  NUM_PORTS  per-port data valid.
- in_ready  out  NUM_PORTS  per-port accept; one-hot or zero.
- data_in_p  in  NUM_PORTS*DATA_W  packed data; port i at [i*DATA_W +: DATA_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- data_out  out  DATA_W  registered output data.
- out_port  out  PORT_W  index of the port that sourced data_out.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, data_out=0, out_port=0.
  - RR pointer=0, all credits=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer drops the pending output beat.
- Output stage:
  - One register; load_en = ~out_valid | out_ready.
  - in_ready[g] = load_en & grant[g], combinational from registered state and in_valid. No valid-to-ready loop is allowed on the input side.
  - Beat accepted at edge T appears on data_out/out_port with out_valid=1 after edge T (latency 1).
  - With out_ready held high, throughput is 1 beat per cycle.
  - out_valid=1 & out_ready=0: data_out and out_port hold, and in_ready=0.
- SP mode:
  - Grant goes to the lowest-index port with in_valid=1. Port 0 has highest priority.
  - Credits and pointer are frozen.
- WRR mode:
  - Each port has a credit counter of WEIGHT_W bits.
  - Eligible port = in_valid=1 and credit>0.
  - Grant goes to the first eligible port scanning from the pointer upward, with wrap-around modulo NUM_PORTS.
  - On acceptance, the granted port's credit decrements.
  - If the new credit is 0, the pointer moves to grant+1 (wrap to 0 after NUM_PORTS-1). Otherwise the pointer stays at the granted port.
  - Reload: if any port has in_valid but no port is eligible, all credits load from weight_p in that cycle. Grant is computed on the reloaded values (no bubble).
  - A weight of 0 is treated as 1.
  - weight_p is sampled only at reload.
- Mode switch:
  - sp0_wrr1 takes effect on the next grant decision.
  - Switching into WRR forces a reload.
- No requests: in_ready=0, no state change. out_valid drops after the last beat drains.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined:
  - Adds input port in_last (NUM_PORTS bits).
  - Once a port is granted, the grant locks to it until a beat with in_last[g]=1 is accepted.
  - Other ports get in_ready=0 during the lock.
  - In WRR, credit decrements per packet, not per beat.
  - Reset clears the lock.
- Not defined:
  - in_last is absent.
  - Arbitration is per beat exactly as described above.

Decomposition:
- Package arb_pkg holds:
  - mode constants ARB_MODE_SP=1'b0 and ARB_MODE_WRR=1'b1.
  - a function for the rotate-and-find-first priority search.
  - default width localparams.
- One sub-module is natural: rr_prio_pick (NUM_PORTS), which takes a request vector and pointer and returns a one-hot grant plus its index.
- The WRR scan uses rr_prio_pick with the requested pointer. SP uses it with pointer=0.

Test Plan:
- Reset / idle:
  - Stimulus: rst=1 for 3 cycles, with in_valid=all ones and out_ready=1.
  - Response: in_ready=0, out_valid=0 throughout. First grant goes to port 0 in the cycle after rst falls.
- SP priority:
  - Stimulus: sp0_wrr1=0, ports 3 and 7 continuously valid, out_ready=1.
  - Response: only port 3 is served. out_port=3 on every beat. Port 7 starves.
- WRR weights:
  - Stimulus: NUM_PORTS=4, weights {1,2,0,3}, all ports valid, out_ready=1.
  - Response: out_port sequence repeats 0,1,1,2,3,3,3 with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while a beat is held.
  - Response: data_out and out_port are stable and in_ready=0. Once out_ready=1, beats resume with no loss or duplication.
- Wrap and reload:
  - Stimulus: pointer at port 15, only ports 15 and 0 valid, each with weight 1.
  - Response: grants 15, 0, 15, 0…, with reload and no idle cycle.
- Packet lock (with ARB_PKT_LOCK_EN):
  - Stimulus: port 2 sends a 4-beat packet while higher-priority port 0 raises valid mid-packet in SP mode.
  - Response: all 4 beats from port 2 complete before out_port=0.
